song_player: RTL and testbench
==============================

Name: song_player

Overview:
- Playback engine at the far end of the game-flow interface. Consumes the game state and the one-cycle song_confirm code, and steps through a per-song note ROM at a fixed beat rate.
- Drives note outputs to the tone generator and LED-matrix renderer.
- Returns a one-cycle finish pulse that moves the game from PLAY to FINISH.

Parameters:
- BEAT_DIV, 12_500_000, clk cycles per beat (use 4 in simulation)
- IDX_W, 6, note-index width per song (64 entries per song)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_state  in  2  game FSM state (START=0, MENU=1, PLAY=2, FINISH=3)
- song_confirm  in  2  one-cycle song code (1..3) when confirm is pressed; 0 otherwise
- note  out  4  current note code; 0 = rest/mute
- note_valid  out  1  high while a ROM note is being sounded
- beat  out  1  one-cycle pulse at each beat boundary while playing
- playing  out  1  high in LOAD and PLAY
- song_id  out  2  latched song code; 0 when idle
- finish  out  1  one-cycle pulse at end of song

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; note=0, note_valid=0, beat=0, playing=0, song_id=0, finish=0; beat counter=0, index=0.
- ROM entry (6 bits) = {dur[1:0], code[3:0]}:
  - code 4'hF = END marker.
  - code 0 = rest.
  - A note lasts (dur+1)*BEAT_DIV cycles.
- ROM address = {song_id, index}. Read is synchronous with 1-cycle latency.
- FSM IDLE -> LOAD -> PLAY -> DONE -> IDLE.
- IDLE:
  - Accept only when song_confirm!=0 AND game_state==MENU.
  - Confirms seen in START or FINISH (yellow presses) are ignored.
  - On accept: latch song_id, index=0, issue ROM read, go to LOAD.
- LOAD: one wait cycle for ROM data, then go to PLAY. Accept at cycle t gives first note valid at t+2.
- PLAY:
  - Load the fetched entry into note/dur. note_valid=1.
  - Beat counter counts 0..BEAT_DIV-1; beat pulses when it wraps.
  - After (dur+1) beats: increment index, issue the next read, hold the previous note during the 1-cycle fetch gap, then load the new entry.
- END handling: when the fetched code is 4'hF, do not sound it. Set note=0, note_valid=0, pulse finish for exactly one cycle, go to DONE.
- Index wrap: if index reaches 2^IDX_W-1 with no END entry, that entry is treated as END (forced finish). Index never wraps to 0.
- DONE: stay until game_state!=PLAY, then go to IDLE and clear song_id. This guarantees a single finish pulse per song.
- Abort: in LOAD/PLAY, if game_state==START or MENU (upstream reset or desync), go to IDLE next cycle. Mute immediately, no finish pulse.
- Confirm while LOAD/PLAY/DONE: ignored. A song is never restarted mid-play.
- Simultaneous events:
  - Abort and END in the same cycle: abort wins, finish=0.
  - rst overrides everything.
- song_confirm is never 0 on accept: the accept condition already requires it nonzero.

Decomposition:
- Shared package game_pkg:
  - Game-state encodings START/MENU/PLAY/FINISH (shared with the game FSM).
  - NOTE_REST=4'h0, NOTE_END=4'hF.
  - ROM entry field widths.
  - Player FSM state enum.
- One sub-module: song_rom (sync-read, 1-cycle latency, contents from an init file, 3 songs x 2^IDX_W entries; song 0 region unused).

Test Plan (BEAT_DIV=4):
- Reset, then game_state=MENU, song_confirm=2 for 1 cycle -> playing=1 next cycle, note_valid=1 two cycles after accept, song_id=2, note equals ROM[2][0].code.
- Song 1 = {dur1 C, dur0 rest, END} -> C held 8 cycles, rest 4 cycles with note_valid=1 and note=0, then finish high exactly 1 cycle; after game_state=FINISH, song_id=0 and the FSM is IDLE.
- song_confirm=3 while game_state=FINISH, and song_confirm=1 while game_state=START -> no state change, playing stays 0.
- During PLAY of song 2, pulse song_confirm=1 -> song_id stays 2, index and note sequence unaffected.
- Mid-song, force game_state=START -> next cycle note=0, playing=0, finish never asserted.
- Song 3 region with no END marker -> forced finish exactly when index reaches 63; rst asserted mid-note on a later run returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: game-flow encodings, ROM entry layout, player states and song table
package game_pkg;
    typedef enum logic [1:0] {GS_START = 2'd0, GS_MENU = 2'd1, GS_PLAY = 2'd2, GS_FINISH = 2'd3} game_state_e;
    typedef enum logic [1:0] {P_IDLE, P_LOAD, P_PLAY, P_DONE} player_state_e;
    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END = 4'hF;
    localparam int CODE_W = 4;
    localparam int DUR_W = 2;
    localparam int ENTRY_W = DUR_W + CODE_W;
    typedef struct packed {
        logic [DUR_W-1:0] dur;
        logic [CODE_W-1:0] code;
    } rom_entry_t;
    // Song 3 deliberately has no END marker so it runs to the last index.
    function automatic logic [ENTRY_W-1:0] song_entry(input logic [1:0] s, input int unsigned i);
        logic [ENTRY_W-1:0] e;
        e = {2'd0, NOTE_END};
        if (s == 2'd1) e = i == 0 ? {2'd1, 4'h1} : i == 1 ? {2'd0, NOTE_REST} : e;
        if (s == 2'd2) e = i == 0 ? {2'd0, 4'h3} : i == 1 ? {2'd1, 4'h5} : i == 2 ? {2'd0, 4'h8} : e;
        if (s == 2'd3) e = {2'd0, 4'(i % 15)};
        return e;
    endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read note table, 3 songs x 2^IDX_W entries, one cycle latency
module song_rom import game_pkg::*; #(
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic [IDX_W+1:0]   addr,
    output logic [ENTRY_W-1:0] data
);
    logic [ENTRY_W-1:0] data_q;
    always_ff @(posedge clk) data_q <= song_entry(addr[IDX_W+1:IDX_W], 32'(addr[IDX_W-1:0]));
    assign data = data_q;
endmodule

// File: rtl/song_player.sv
// song_player: steps a per-song note ROM at a fixed beat rate and signals end of song
module song_player import game_pkg::*; #(
    parameter int BEAT_DIV = 12_500_000,
    parameter int IDX_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic [1:0] song_confirm,
    output logic [3:0] note,
    output logic       note_valid,
    output logic       beat,
    output logic       playing,
    output logic [1:0] song_id,
    output logic       finish
);
    localparam int CNT_W = $clog2(BEAT_DIV + 1);

    player_state_e state_q, state_d;
    logic [1:0] song_id_q, song_id_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0] note_q, note_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic note_valid_q, note_valid_d, beat_q, beat_d, playing_q, playing_d;
    logic finish_q, finish_d, fetch_q, fetch_d;
    logic [ENTRY_W-1:0] rom_data;
    rom_entry_t entry;
    logic wrap, abort;

    song_rom #(.IDX_W(IDX_W)) u_rom (.clk(clk), .addr({song_id_d, idx_d}), .data(rom_data));

    assign entry = rom_data;
    assign wrap = cnt_q == CNT_W'(BEAT_DIV - 1);
    assign abort = game_state == GS_START || game_state == GS_MENU;

    always_comb begin
        state_d = state_q;
        song_id_d = song_id_q;
        idx_d = idx_q;
        note_d = note_q;
        dur_d = dur_q;
        cnt_d = cnt_q;
        note_valid_d = note_valid_q;
        playing_d = playing_q;
        fetch_d = fetch_q;
        beat_d = 1'b0;
        finish_d = 1'b0;
        if ((state_q == P_LOAD || state_q == P_PLAY) && abort) begin
            state_d = P_IDLE;
            song_id_d = '0;
            idx_d = '0;
            note_d = NOTE_REST;
            note_valid_d = 1'b0;
            playing_d = 1'b0;
            fetch_d = 1'b0;
            cnt_d = '0;
        end else begin
            case (state_q)
                P_IDLE: if (song_confirm != 2'd0 && game_state == GS_MENU) begin
                    state_d = P_LOAD;
                    song_id_d = song_confirm;
                    idx_d = '0;
                    playing_d = 1'b1;
                    cnt_d = '0;
                end
                P_LOAD: begin
                    state_d = P_PLAY;
                    fetch_d = 1'b1;
                end
                P_PLAY: begin
                    cnt_d = wrap ? '0 : cnt_q + 1'b1;
                    beat_d = wrap;
                    // The fetch cycle is beat cycle 0, so each note spans exactly (dur+1) beats.
                    if (fetch_q && (entry.code == NOTE_END || &idx_q)) begin
                        state_d = P_DONE;
                        note_d = NOTE_REST;
                        note_valid_d = 1'b0;
                        playing_d = 1'b0;
                        finish_d = 1'b1;
                        fetch_d = 1'b0;
                        cnt_d = '0;
                    end else if (fetch_q) begin
                        note_d = entry.code;
                        dur_d = entry.dur;
                        note_valid_d = 1'b1;
                        fetch_d = 1'b0;
                    end else if (wrap && dur_q == '0) begin
                        idx_d = idx_q + 1'b1;
                        fetch_d = 1'b1;
                    end else if (wrap) dur_d = dur_q - 1'b1;
                end
                P_DONE: if (game_state != GS_PLAY) begin
                    state_d = P_IDLE;
                    song_id_d = '0;
                    idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= P_IDLE;
            song_id_q <= '0;
            idx_q <= '0;
            note_q <= '0;
            dur_q <= '0;
            cnt_q <= '0;
            note_valid_q <= 1'b0;
            beat_q <= 1'b0;
            playing_q <= 1'b0;
            finish_q <= 1'b0;
            fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            song_id_q <= song_id_d;
            idx_q <= idx_d;
            note_q <= note_d;
            dur_q <= dur_d;
            cnt_q <= cnt_d;
            note_valid_q <= note_valid_d;
            beat_q <= beat_d;
            playing_q <= playing_d;
            finish_q <= finish_d;
            fetch_q <= fetch_d;
        end
    end

    assign note = note_q;
    assign note_valid = note_valid_q;
    assign beat = beat_q;
    assign playing = playing_q;
    assign song_id = song_id_q;
    assign finish = finish_q;
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: event scoreboard over note/valid/finish/song_id/playing changes
module tb_song_player;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] game_state = 2'd0;
    logic [1:0] song_confirm = 2'd0;
    logic [3:0] note;
    logic note_valid, beat, playing, finish;
    logic [1:0] song_id;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int a, b, c, d, e, f;

    typedef struct {
        int cyc;
        logic [3:0] note;
        logic nv;
        logic fin;
        logic [1:0] sid;
        logic play;
    } ev_t;
    ev_t q[$];
    ev_t x;
    logic [8:0] prev = '0;

    song_player #(.BEAT_DIV(4), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .game_state(game_state), .song_confirm(song_confirm),
        .note(note), .note_valid(note_valid), .beat(beat), .playing(playing),
        .song_id(song_id), .finish(finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mon_en) begin
        if ({note, note_valid, finish, song_id, playing} !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got note=%0h nv=%b fin=%b sid=%0d play=%b, want no change",
                         cyc, note, note_valid, finish, song_id, playing);
            end else begin
                x = q.pop_front();
                if (x.cyc != cyc || x.note !== note || x.nv !== note_valid || x.fin !== finish ||
                    x.sid !== song_id || x.play !== playing) begin
                    n_bad++;
                    $display("FAIL event got cyc=%0d note=%0h nv=%b fin=%b sid=%0d play=%b want cyc=%0d note=%0h nv=%b fin=%b sid=%0d play=%b",
                             cyc, note, note_valid, finish, song_id, playing, x.cyc, x.note, x.nv, x.fin, x.sid, x.play);
                end
            end
        end
        prev <= {note, note_valid, finish, song_id, playing};
    end

    task automatic go(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic ex(input int cy, input int n, input int v, input int fi, input int s, input int p);
        q.push_back('{cy, 4'(n), 1'(v), 1'(fi), 2'(s), 1'(p)});
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "timeout");
    end

    initial begin
        go(3);
        rst = 1'b0;
        chk("rst_note", 32'(note), 0);
        chk("rst_note_valid", 32'(note_valid), 0);
        chk("rst_beat", 32'(beat), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_song_id", 32'(song_id), 0);
        chk("rst_finish", 32'(finish), 0);
        mon_en = 1'b1;
        // song 1: C for two beats, rest for one, then END
        go(5);
        a = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd1;
        ex(a, 0, 0, 0, 1, 1);
        ex(a + 2, 1, 1, 0, 1, 1);
        ex(a + 10, 0, 1, 0, 1, 1);
        ex(a + 14, 0, 0, 1, 1, 0);
        ex(a + 15, 0, 0, 0, 1, 0);
        go(a);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(a + 16);
        game_state = 2'd3;
        ex(a + 17, 0, 0, 0, 0, 0);
        // confirms outside MENU are ignored
        go(a + 20);
        song_confirm = 2'd3;
        go(a + 21);
        game_state = 2'd0;
        song_confirm = 2'd1;
        go(a + 22);
        song_confirm = 2'd0;
        go(a + 24);
        chk("ignore_playing", 32'(playing), 0);
        chk("ignore_song_id", 32'(song_id), 0);
        // song 2 with a stray confirm mid-play
        go(a + 26);
        b = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd2;
        ex(b, 0, 0, 0, 2, 1);
        ex(b + 2, 3, 1, 0, 2, 1);
        ex(b + 6, 5, 1, 0, 2, 1);
        ex(b + 14, 8, 1, 0, 2, 1);
        ex(b + 18, 0, 0, 1, 2, 0);
        ex(b + 19, 0, 0, 0, 2, 0);
        go(b);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(b + 5);
        chk("beat_pulse", 32'(beat), 1);
        go(b + 6);
        chk("beat_low", 32'(beat), 0);
        go(b + 7);
        song_confirm = 2'd1;
        go(b + 8);
        song_confirm = 2'd0;
        go(b + 9);
        chk("confirm_mid_song_id", 32'(song_id), 2);
        go(b + 20);
        game_state = 2'd3;
        ex(b + 21, 0, 0, 0, 0, 0);
        // abort mid-song
        go(b + 24);
        c = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd2;
        ex(c, 0, 0, 0, 2, 1);
        ex(c + 2, 3, 1, 0, 2, 1);
        ex(c + 6, 5, 1, 0, 2, 1);
        ex(c + 9, 0, 0, 0, 0, 0);
        go(c);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(c + 8);
        game_state = 2'd0;
        // abort coinciding with END fetch: no finish
        go(c + 12);
        d = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd1;
        ex(d, 0, 0, 0, 1, 1);
        ex(d + 2, 1, 1, 0, 1, 1);
        ex(d + 10, 0, 1, 0, 1, 1);
        ex(d + 14, 0, 0, 0, 0, 0);
        go(d);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(d + 13);
        game_state = 2'd0;
        // song 3: no END, forced finish at index 63
        go(d + 16);
        e = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd3;
        ex(e, 0, 0, 0, 3, 1);
        for (int i = 0; i < 63; i++) ex(e + 2 + 4 * i, i % 15, 1, 0, 3, 1);
        ex(e + 254, 0, 0, 1, 3, 0);
        ex(e + 255, 0, 0, 0, 3, 0);
        go(e);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(e + 256);
        game_state = 2'd3;
        ex(e + 257, 0, 0, 0, 0, 0);
        // reset mid-note
        go(e + 260);
        f = cyc + 1;
        game_state = 2'd1;
        song_confirm = 2'd1;
        ex(f, 0, 0, 0, 1, 1);
        ex(f + 2, 1, 1, 0, 1, 1);
        ex(f + 6, 0, 0, 0, 0, 0);
        go(f);
        song_confirm = 2'd0;
        game_state = 2'd2;
        go(f + 5);
        rst = 1'b1;
        go(f + 6);
        rst = 1'b0;
        game_state = 2'd0;
        chk("rst_mid_beat", 32'(beat), 0);
        chk("rst_mid_note", 32'(note), 0);
        chk("rst_mid_playing", 32'(playing), 0);
        go(f + 16);
        chk("pending_events", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
